// File: rtl/freq_meter_pkg.sv
// Shared timing definitions for the clock divider, stopwatch and frequency meter.
// Holds the default system clock rate and the counter-width helper.
package freq_meter_pkg;

    localparam int CLK_FREQ_DEFAULT = 50_000_000;

    // Bits needed to hold the values 0..value-1; never less than one bit.
    function automatic int ceillog2(input longint value);
        longint v;
        int     bits;
        v    = value - 1;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge register for an asynchronous level input.
// Emits a one-cycle rise pulse per synchronized low-to-high transition.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta;
    logic s1;
    logic s2;

    // NOTE: reset is asynchronous and active-low; every flop here is cleared so
    // that no stale level can produce a spurious rise right after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true three-stage shift.
            meta <= d;
            s1   <= meta;
            s2   <= s1;
        end
    end

    assign rise = s1 & ~s2;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a fixed
// gate window and publishes the saturated count once per window with a valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int GATE_MS  = 1000,
    parameter int WIDTH    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] freq_out,
    output logic             ovf,
    output logic             valid
);

    localparam longint GATE_CYCLES = longint'(CLK_FREQ) / 1000 * longint'(GATE_MS);
    localparam int     GATE_W      = ceillog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

    logic              rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [WIDTH-1:0]  edge_cnt;
    logic              sat;
    logic              closing;
    logic [WIDTH-1:0]  cnt_next;
    logic              sat_next;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .rise (rise)
    );

    assign closing = en && (gate_cnt == GATE_LAST);

    // Edge count including this cycle's rise, pinned at full scale once reached.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch forms.
        cnt_next = edge_cnt;
        sat_next = sat;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_cnt <= '0;
        end else if (!en || closing) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // A closing cycle hands its count to the result and restarts from zero, so
    // back-to-back windows have no dead cycle between them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (!en || closing) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            edge_cnt <= cnt_next;
            sat      <= sat_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_out <= '0;
            ovf      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= closing;
            if (closing) begin
                freq_out <= cnt_next;
                ovf      <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (8-bit and 4-bit results) share
// stimulus and are compared every cycle against a window-level edge-counting model.
module tb_freq_meter;

    localparam int GATE = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sig_in;
    logic [7:0] freq8;
    logic       ovf8;
    logic       valid8;
    logic [3:0] freq4;
    logic       ovf4;
    logic       valid4;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    freq_meter #(.CLK_FREQ(100_000), .GATE_MS(1), .WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .freq_out (freq8),
        .ovf      (ovf8),
        .valid    (valid8)
    );

    freq_meter #(.CLK_FREQ(100_000), .GATE_MS(1), .WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .freq_out (freq4),
        .ovf      (ovf4),
        .valid    (valid4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clip(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    // Model: sig_in levels seen at each clock edge; a low-to-high step between the
    // samples taken three and two edges ago is an edge credited to the current
    // edge. Each run of GATE consecutive enabled edges forms one window.
    logic [2:0] hist;
    int         acc;
    int         k;
    logic       m_valid;
    int         m_f8, m_f4;
    logic       m_o8, m_o4;
    int         m_total;

    assign m_total = acc + int'(hist[1] & ~hist[2]);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            acc     <= 0;
            k       <= 0;
            m_valid <= 1'b0;
            m_f8    <= 0;
            m_o8    <= 1'b0;
            m_f4    <= 0;
            m_o4    <= 1'b0;
        end else begin
            hist    <= {hist[1:0], sig_in};
            m_valid <= 1'b0;
            if (!en) begin
                acc <= 0;
                k   <= 0;
            end else if (k == GATE - 1) begin
                m_valid <= 1'b1;
                m_f8    <= clip(m_total, 8);
                m_o8    <= (m_total > 255);
                m_f4    <= clip(m_total, 4);
                m_o4    <= (m_total > 15);
                acc     <= 0;
                k       <= 0;
            end else begin
                acc <= m_total;
                k   <= k + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("valid8", int'(valid8), int'(m_valid));
        check("freq8",  int'(freq8),  m_f8);
        check("ovf8",   int'(ovf8),   int'(m_o8));
        check("valid4", int'(valid4), int'(m_valid));
        check("freq4",  int'(freq4),  m_f4);
        check("ovf4",   int'(ovf4),   int'(m_o4));
    end

    // Record the most recent published results and the spacing between strobes.
    int nvalid   = 0;
    int last_cyc = 0;
    int gap      = 0;
    int last8    = 0;
    int prev8    = 0;
    int last4    = 0;

    always @(negedge clk) begin
        if (valid8) begin
            nvalid   <= nvalid + 1;
            gap      <= cyc - last_cyc;
            last_cyc <= cyc;
            last8    <= int'(freq8);
            prev8    <= last8;
            last4    <= int'(freq4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic logic wave(input int i, input int p);
        if (p == 0) return 1'b0;
        return ((i % p) < (p / 2));
    endfunction

    task automatic run(input int n, input int p, input int off);
        for (int i = 0; i < n; i++) begin
            sig_in = wave(i + off, p);
            tick();
        end
    endtask

    task automatic idle();
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (5) tick();
    endtask

    // Cycles from enabling until the first strobe; -1 when none appears in budget.
    task automatic wait_valid(input int off, input int p, output int lat);
        lat = -1;
        for (int j = 1; j <= 150; j++) begin
            sig_in = wave(off + j - 1, p);
            @(posedge clk);
            @(negedge clk);
            #1;
            if (valid8) begin
                lat = j;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int lat;

        rst    = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();
        check("rst_freq8",  int'(freq8),  0);
        check("rst_ovf8",   int'(ovf8),   0);
        check("rst_valid8", int'(valid8), 0);
        rst = 1'b1;
        idle();

        // Steady period-10 wave: ten edges per window, strobes 100 cycles apart.
        en = 1'b1;
        n0 = nvalid;
        run(300, 10, 0);
        settle();
        check("t1_strobes", nvalid - n0, 3);
        check("t1_freq8",   last8, 10);
        check("t1_freq4",   last4, 10);
        check("t1_ovf8",    int'(ovf8), 0);
        check("t1_gap",     gap, 100);
        idle();

        // Quiet input for a whole window.
        en = 1'b1;
        n0 = nvalid;
        run(100, 0, 0);
        settle();
        check("t2_strobes", nvalid - n0, 1);
        check("t2_freq8",   int'(freq8), 0);
        check("t2_ovf8",    int'(ovf8), 0);
        idle();

        // 25 edges saturate the 4-bit result; the following window recovers.
        en = 1'b1;
        n0 = nvalid;
        run(100, 4, 0);
        settle();
        check("t3_freq4_sat", int'(freq4), 15);
        check("t3_ovf4_sat",  int'(ovf4),  1);
        check("t3_freq8",     int'(freq8), 25);
        check("t3_ovf8",      int'(ovf8),  0);
        run(100, 10, 0);
        settle();
        check("t3_freq4_rec", int'(freq4), 10);
        check("t3_ovf4_rec",  int'(ovf4),  0);
        check("t3_strobes",   nvalid - n0, 2);
        idle();

        // Extra pulse early plus an edge credited on the closing cycle: 11, then 10.
        en = 1'b1;
        n0 = nvalid;
        sig_in = 1'b0; tick();
        sig_in = 1'b1; tick();
        sig_in = 1'b0;
        repeat (5) tick();
        run(200, 10, 0);
        settle();
        check("t4_strobes",   nvalid - n0, 2);
        check("t4_close_win", prev8, 11);
        check("t4_next_win",  last8, 10);
        idle();

        // Enable dropped mid-window: partial window discarded, result held.
        en = 1'b1;
        run(50, 10, 0);
        en = 1'b0;
        n0 = nvalid;
        run(20, 10, 50);
        settle();
        check("t5_gap_strobes", nvalid - n0, 0);
        check("t5_hold_freq8",  int'(freq8), 10);
        en = 1'b1;
        wait_valid(70, 10, lat);
        check("t5_latency", lat, 100);
        check("t5_freq8",   int'(freq8), 10);
        idle();

        // Asynchronous reset between clock edges clears outputs at once.
        en = 1'b1;
        run(40, 10, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_freq8",  int'(freq8),  0);
        check("t6_rst_freq4",  int'(freq4),  0);
        check("t6_rst_ovf8",   int'(ovf8),   0);
        check("t6_rst_valid8", int'(valid8), 0);
        sig_in = 1'b0;
        en     = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        en = 1'b1;
        wait_valid(0, 10, lat);
        check("t6_latency", lat, 100);
        check("t6_freq8",   int'(freq8), 10);
        check("t6_ovf8",    int'(ovf8),  0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
